// File: rtl/pipeline_split.sv
// pipeline_split: fans one ready/valid input out to OUTPUT_COUNT independent
// ready/valid outputs. Each output owns a 2-entry buffer (main + skid). Because
// of that buffer, input_ready is computed from registered occupancy only, and
// the block still sustains one word per cycle when every consumer is ready.
module pipeline_split #(
    parameter int WORD_WIDTH   = 8,
    parameter int OUTPUT_COUNT = 2,
    localparam int TOTAL_WIDTH = WORD_WIDTH * OUTPUT_COUNT
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic [TOTAL_WIDTH-1:0]  input_data,
    output logic [OUTPUT_COUNT-1:0] output_valid,
    input  logic [OUTPUT_COUNT-1:0] output_ready,
    output logic [TOTAL_WIDTH-1:0]  output_data
);

    typedef logic [1:0] count_t;

    localparam count_t CNT_EMPTY = 2'd0;
    localparam count_t CNT_ONE   = 2'd1;
    localparam count_t CNT_FULL  = 2'd2;

    // Per-output storage. main always holds the oldest undelivered word.
    logic [OUTPUT_COUNT-1:0][WORD_WIDTH-1:0] main_q, main_d;
    logic [OUTPUT_COUNT-1:0][WORD_WIDTH-1:0] skid_q, skid_d;
    count_t [OUTPUT_COUNT-1:0]               count_q, count_d;

    logic [OUTPUT_COUNT-1:0] full;
    logic [OUTPUT_COUNT-1:0] deq;
    logic                    acc;

    // Status decode from registered occupancy only.
    always_comb begin
        output_valid = '0;
        full         = '0;
        for (int j = 0; j < OUTPUT_COUNT; j++) begin
            output_valid[j] = (count_q[j] != CNT_EMPTY);
            full[j]         = (count_q[j] == CNT_FULL);
        end
    end

    // A full buffer on any output stalls the whole input; no partial accepts.
    assign input_ready = clear_n & ~(|full);
    assign acc         = input_valid & input_ready;
    assign deq         = output_valid & output_ready;
    assign output_data = main_q;

    // Per-output next state: enqueue on accept, dequeue on drain.
    always_comb begin
        // NOTE: every *_d gets its hold value first so no path leaves it unassigned (no latch).
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q;
        for (int j = 0; j < OUTPUT_COUNT; j++) begin
            unique case ({acc, deq[j]})
                2'b10: begin
                    if (count_q[j] == CNT_EMPTY) begin
                        count_d[j] = CNT_ONE;
                        main_d[j]  = input_data[WORD_WIDTH*j +: WORD_WIDTH];
                    end else begin
                        count_d[j] = CNT_FULL;
                        skid_d[j]  = input_data[WORD_WIDTH*j +: WORD_WIDTH];
                    end
                end
                2'b01: begin
                    if (count_q[j] == CNT_FULL) begin
                        count_d[j] = CNT_ONE;
                        main_d[j]  = skid_q[j];
                    end else begin
                        count_d[j] = CNT_EMPTY;
                    end
                end
                2'b11: begin
                    // Only reachable with exactly one word held: stream through main.
                    count_d[j] = CNT_ONE;
                    main_d[j]  = input_data[WORD_WIDTH*j +: WORD_WIDTH];
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous clear that overrides any handshake.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            // NOTE: the data buffers are cleared too, since output_data must read zero after reset.
            main_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            main_q  <= main_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_pipeline_split.sv
// Testbench for pipeline_split (WORD_WIDTH=8, OUTPUT_COUNT=2). Stimulus pushes
// expected slices into per-output queues on each accepted input; a monitor
// pops and compares whenever an output handshake completes.
module tb_pipeline_split;

    localparam int W  = 8;
    localparam int OC = 2;
    localparam int TW = W * OC;

    logic          clock;
    logic          clear_n;
    logic          input_valid;
    logic          input_ready;
    logic [TW-1:0] input_data;
    logic [OC-1:0] output_valid;
    logic [OC-1:0] output_ready;
    logic [TW-1:0] output_data;

    logic [W-1:0] exp_q [OC][$];

    int total = 0;
    int bad   = 0;

    pipeline_split #(.WORD_WIDTH(W), .OUTPUT_COUNT(OC)) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_expected(input logic [TW-1:0] d);
        for (int j = 0; j < OC; j++) exp_q[j].push_back(d[W*j +: W]);
    endtask

    // Called at a falling edge; returns at a later falling edge with input_valid still high.
    task automatic send(input logic [TW-1:0] d, output int waited);
        bit done;
        done        = 1'b0;
        waited      = 0;
        input_valid = 1'b1;
        input_data  = d;
        while (!done && waited < 50) begin
            #4;
            if (input_ready) begin
                push_expected(d);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(negedge clock);
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: sampled mid-low-phase, before the stimulus records this cycle's accept.
    always begin
        @(negedge clock);
        #3;
        for (int j = 0; j < OC; j++) begin
            if (output_valid[j] && output_ready[j]) begin
                if (exp_q[j].size() == 0) begin
                    check($sformatf("out%0d_unexpected_word", j), 32'd1, 32'd0);
                end else begin
                    check($sformatf("out%0d_data", j),
                          32'(output_data[W*j +: W]), 32'(exp_q[j].pop_front()));
                end
            end
        end
        if (exp_q[0].size() >= 2 || exp_q[1].size() >= 2)
            check("ready_when_full", 32'(input_ready), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        clear_n      = 1'b0;
        input_valid  = 1'b0;
        input_data   = '0;
        output_ready = '0;

        // Reset held for two edges.
        repeat (2) @(posedge clock);
        @(negedge clock);
        #3;
        check("reset_input_ready", 32'(input_ready), 32'd0);
        check("reset_output_valid", 32'(output_valid), 32'd0);
        check("reset_output_data", 32'(output_data), 32'h0000);
        @(negedge clock);
        clear_n = 1'b1;
        #3;
        check("release_input_ready", 32'(input_ready), 32'd1);
        @(negedge clock);

        // First word appears one cycle after accept.
        send(16'hBEEF, w);
        input_valid = 1'b0;
        #3;
        check("first_valid", 32'(output_valid), 32'h3);
        check("first_data", 32'(output_data), 32'hBEEF);
        @(negedge clock);
        output_ready = 2'b11;
        @(negedge clock);
        output_ready = 2'b00;

        // Back-to-back streaming with both consumers ready.
        output_ready = 2'b11;
        for (int i = 1; i <= 16; i++) begin
            send(TW'(i), w);
            check("stream_no_stall", 32'(w), 32'd0);
        end
        input_valid = 1'b0;
        repeat (3) @(negedge clock);

        // Slow consumer on output 1.
        output_ready = 2'b01;
        send(16'hA1B1, w);
        check("slow_accept1", 32'(w), 32'd0);
        send(16'hA2B2, w);
        check("slow_accept2", 32'(w), 32'd0);
        input_valid = 1'b0;
        #3;
        check("slow_ready_low", 32'(input_ready), 32'd0);
        repeat (2) @(negedge clock);
        #3;
        check("slow_ready_still_low", 32'(input_ready), 32'd0);
        check("slow_valid", 32'(output_valid), 32'h2);
        check("slow_hold_a1", 32'(output_data[15:8]), 32'hA1);
        @(negedge clock);
        output_ready = 2'b11;
        @(negedge clock);
        #3;
        check("slow_ready_back", 32'(input_ready), 32'd1);
        check("slow_next_a2", 32'(output_data[15:8]), 32'hA2);
        @(negedge clock);
        output_ready = 2'b00;

        // Accept and drain on both outputs in the same cycle.
        send(16'h1122, w);
        output_ready = 2'b11;
        send(16'h3344, w);
        check("simul_accept", 32'(w), 32'd0);
        input_valid  = 1'b0;
        output_ready = 2'b00;
        #3;
        check("simul_valid", 32'(output_valid), 32'h3);
        check("simul_data", 32'(output_data), 32'h3344);
        @(negedge clock);
        output_ready = 2'b11;
        @(negedge clock);
        output_ready = 2'b00;

        // Reset while both buffers are full.
        send(16'h5566, w);
        send(16'h7788, w);
        input_valid = 1'b0;
        #3;
        check("full_ready_low", 32'(input_ready), 32'd0);
        @(negedge clock);
        clear_n = 1'b0;
        for (int j = 0; j < OC; j++) exp_q[j].delete();
        @(negedge clock);
        clear_n = 1'b1;
        #3;
        check("midreset_valid", 32'(output_valid), 32'd0);
        check("midreset_data", 32'(output_data), 32'h0000);
        check("midreset_ready", 32'(input_ready), 32'd1);
        @(negedge clock);
        output_ready = 2'b11;
        repeat (3) @(negedge clock);
        #3;
        check("midreset_no_ghost", 32'(output_valid), 32'd0);
        @(negedge clock);

        // Random traffic against the reference queues.
        for (int c = 0; c < 400; c++) begin
            input_valid  = 1'($urandom_range(0, 1));
            input_data   = TW'($urandom);
            output_ready = OC'($urandom_range(0, 3));
            #4;
            if (input_valid && input_ready) push_expected(input_data);
            @(negedge clock);
        end
        input_valid  = 1'b0;
        output_ready = 2'b11;
        for (int c = 0; c < 20 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); c++)
            @(negedge clock);
        @(negedge clock);
        check("drain_out0", 32'(exp_q[0].size()), 32'd0);
        check("drain_out1", 32'(exp_q[1].size()), 32'd0);
        #3;
        check("final_idle_valid", 32'(output_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
